// File: rtl/bus_host_arbiter.sv
// Multi-host arbiter for the req/gnt/rvalid memory bus: fixed-priority or round-robin
// selection, stall lock, and an in-order ID FIFO that routes responses back to hosts.
module bus_host_arbiter #(
   parameter int NrHosts        = 3,
   parameter int DataWidth      = 32,
   parameter int AddrWidth      = 32,
   parameter int MaxOutstanding = 2,
   parameter bit RoundRobin     = 1'b0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NrHosts-1:0]             host_req_i,
   input  logic [NrHosts-1:0]             host_we_i,
   input  logic [NrHosts*4-1:0]           host_be_i,
   input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
   input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
   output logic [NrHosts-1:0]             host_gnt_o,
   output logic [NrHosts-1:0]             host_rvalid_o,
   output logic [DataWidth-1:0]           host_rdata_o,
   output logic                           host_err_o,
   output logic                           dev_req_o,
   output logic                           dev_we_o,
   output logic [3:0]                     dev_be_o,
   output logic [AddrWidth-1:0]           dev_addr_o,
   output logic [DataWidth-1:0]           dev_wdata_o,
   input  logic                           dev_gnt_i,
   input  logic                           dev_rvalid_i,
   input  logic [DataWidth-1:0]           dev_rdata_i,
   input  logic                           dev_err_i,
   output logic                           resp_unexpected_o
);

   localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);

   logic [IdW-1:0]  sel;
   logic [IdW-1:0]  lock_id;
   logic [IdW-1:0]  rr_ptr;
   logic [IdW-1:0]  head;
   logic            lock_q;
   logic            lock_hit;
   logic            rr_found;
   int              rr_idx;
   logic            not_full;
   logic            fifo_empty;
   logic            accept;
   logic            pop;
   logic [IdW-1:0]  fifo_q [MaxOutstanding];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [CntW-1:0] cnt;

   // A lock only holds while its host keeps requesting, so a dropped request frees the bus.
   assign lock_hit = lock_q & host_req_i[lock_id];

   always_comb begin
      sel      = '0;
      rr_found = 1'b0;
      rr_idx   = 0;
      if (lock_hit) begin
         sel = lock_id;
      end else if (!RoundRobin) begin
         for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[i]) sel = IdW'(i);
         end
      end else begin
         for (int k = 0; k < NrHosts; k++) begin
            rr_idx = (int'(rr_ptr) + k) % NrHosts;
            if (!rr_found && host_req_i[rr_idx]) begin
               sel      = IdW'(rr_idx);
               rr_found = 1'b1;
            end
         end
      end
   end

   // Full blocks requests even when a pop lands in the same cycle (no bypass path).
   assign not_full          = cnt < CntW'(MaxOutstanding);
   assign fifo_empty        = (cnt == '0);
   assign dev_req_o         = !rst_i & (|host_req_i) & not_full;
   assign accept            = dev_req_o & dev_gnt_i;
   assign pop               = !rst_i & dev_rvalid_i & !fifo_empty;
   assign resp_unexpected_o = !rst_i & dev_rvalid_i & fifo_empty;
   assign head              = fifo_q[rd_ptr];
   assign host_rdata_o      = dev_rdata_i;
   assign host_err_o        = dev_err_i;

   always_comb begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      dev_we_o      = 1'b0;
      dev_be_o      = '0;
      dev_addr_o    = '0;
      dev_wdata_o   = '0;
      for (int i = 0; i < NrHosts; i++) begin
         if (sel == IdW'(i)) begin
            host_gnt_o[i] = accept;
            dev_we_o      = host_we_i[i];
            dev_be_o      = host_be_i[i*4 +: 4];
            dev_addr_o    = host_addr_i[i*AddrWidth +: AddrWidth];
            dev_wdata_o   = host_wdata_i[i*DataWidth +: DataWidth];
         end
         if (head == IdW'(i)) host_rvalid_o[i] = pop;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q  <= 1'b0;
         lock_id <= '0;
         rr_ptr  <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
      end else begin
         lock_q <= dev_req_o & !dev_gnt_i;
         if (dev_req_o && !dev_gnt_i) lock_id <= sel;
         if (accept) begin
            rr_ptr <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + 1'b1;
            wr_ptr <= (wr_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Entries are only meaningful below cnt, so the storage needs no reset.
   always_ff @(posedge clk_i) begin
      if (accept) fifo_q[wr_ptr] <= sel;
   end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter: a fixed-priority and a round-robin instance share
// the same stimulus; each scenario task checks the instance it exercises.
module tb_bus_host_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   we;
   logic [N*4-1:0] be;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic           dev_gnt;
   logic           dev_rvalid;
   logic [DW-1:0]  dev_rdata;
   logic           dev_err;

   logic [N-1:0]   fp_gnt, fp_rvalid, rr_gnt, rr_rvalid;
   logic [DW-1:0]  fp_rdata, rr_rdata, fp_wdata, rr_wdata;
   logic [AW-1:0]  fp_addr, rr_addr;
   logic [3:0]     fp_be, rr_be;
   logic           fp_err, rr_err, fp_req, rr_req, fp_we, rr_we, fp_unexp, rr_unexp;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bus_host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddrWidth(AW),
                      .MaxOutstanding(2), .RoundRobin(1'b0)) dut_fp (
      .clk_i(clk), .rst_i(rst),
      .host_req_i(req), .host_we_i(we), .host_be_i(be), .host_addr_i(addr),
      .host_wdata_i(wdata),
      .host_gnt_o(fp_gnt), .host_rvalid_o(fp_rvalid), .host_rdata_o(fp_rdata),
      .host_err_o(fp_err),
      .dev_req_o(fp_req), .dev_we_o(fp_we), .dev_be_o(fp_be), .dev_addr_o(fp_addr),
      .dev_wdata_o(fp_wdata),
      .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
      .dev_err_i(dev_err),
      .resp_unexpected_o(fp_unexp)
   );

   bus_host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddrWidth(AW),
                      .MaxOutstanding(2), .RoundRobin(1'b1)) dut_rr (
      .clk_i(clk), .rst_i(rst),
      .host_req_i(req), .host_we_i(we), .host_be_i(be), .host_addr_i(addr),
      .host_wdata_i(wdata),
      .host_gnt_o(rr_gnt), .host_rvalid_o(rr_rvalid), .host_rdata_o(rr_rdata),
      .host_err_o(rr_err),
      .dev_req_o(rr_req), .dev_we_o(rr_we), .dev_be_o(rr_be), .dev_addr_o(rr_addr),
      .dev_wdata_o(rr_wdata),
      .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
      .dev_err_i(dev_err),
      .resp_unexpected_o(rr_unexp)
   );

   function automatic logic [AW-1:0] host_addr(int h);
      return 32'h0000_1000 + 32'(h) * 32'h10;
   endfunction

   // Advance to just after the next rising edge, where the bench drives new inputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req        = '0;
      dev_gnt    = 1'b0;
      dev_rvalid = 1'b0;
      dev_rdata  = '0;
      dev_err    = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      req        = 3'b111;
      dev_gnt    = 1'b1;
      dev_rvalid = 1'b1;
      #2;
      checks++; if (fp_gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt got=%b exp=000", fp_gnt); end
      checks++; if (fp_rvalid !== 3'b000) begin errors++; $display("[TB] FAIL reset_rvalid got=%b exp=000", fp_rvalid); end
      checks++; if (fp_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_dev_req got=%b exp=0", fp_req); end
      checks++; if (fp_unexp !== 1'b0) begin errors++; $display("[TB] FAIL reset_unexpected got=%b exp=0", fp_unexp); end
      tick();
      rst = 1'b0;
      clear_inputs();
      tick();
   endtask

   task automatic test_fixed_priority();
      pulse_reset();
      req = 3'b101; dev_gnt = 1'b1;
      #1;
      checks++; if (fp_gnt !== 3'b001) begin errors++; $display("[TB] FAIL fp_c0_gnt got=%b exp=001", fp_gnt); end
      checks++; if (fp_addr !== host_addr(0)) begin errors++; $display("[TB] FAIL fp_c0_addr got=%h exp=%h", fp_addr, host_addr(0)); end
      checks++; if (fp_wdata !== 32'hA0) begin errors++; $display("[TB] FAIL fp_c0_wdata got=%h exp=a0", fp_wdata); end
      tick();
      req = 3'b100; dev_rvalid = 1'b1; dev_rdata = 32'h1111_0000;
      #1;
      checks++; if (fp_gnt !== 3'b100) begin errors++; $display("[TB] FAIL fp_c1_gnt got=%b exp=100", fp_gnt); end
      checks++; if (fp_addr !== host_addr(2)) begin errors++; $display("[TB] FAIL fp_c1_addr got=%h exp=%h", fp_addr, host_addr(2)); end
      checks++; if (fp_rvalid !== 3'b001) begin errors++; $display("[TB] FAIL fp_c1_rvalid got=%b exp=001", fp_rvalid); end
      checks++; if (fp_rdata !== 32'h1111_0000) begin errors++; $display("[TB] FAIL fp_c1_rdata got=%h exp=11110000", fp_rdata); end
      tick();
      req = 3'b000; dev_gnt = 1'b0; dev_rdata = 32'h2222_0000; dev_err = 1'b1;
      #1;
      checks++; if (fp_rvalid !== 3'b100) begin errors++; $display("[TB] FAIL fp_c2_rvalid got=%b exp=100", fp_rvalid); end
      checks++; if (fp_err !== 1'b1) begin errors++; $display("[TB] FAIL fp_c2_err got=%b exp=1", fp_err); end
      checks++; if (fp_gnt !== 3'b000) begin errors++; $display("[TB] FAIL fp_c2_gnt got=%b exp=000", fp_gnt); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_gnt;
      logic [N-1:0] exp_rv;
      pulse_reset();
      req = 3'b111; dev_gnt = 1'b1;
      for (int k = 0; k < 6; k++) begin
         dev_rvalid = (k != 0);
         dev_rdata  = 32'(k);
         exp_gnt    = 3'b001 << (k % 3);
         exp_rv     = (k == 0) ? 3'b000 : 3'b001 << ((k - 1) % 3);
         #1;
         checks++; if (rr_gnt !== exp_gnt) begin errors++; $display("[TB] FAIL rr_gnt_%0d got=%b exp=%b", k, rr_gnt, exp_gnt); end
         checks++; if (rr_rvalid !== exp_rv) begin errors++; $display("[TB] FAIL rr_rvalid_%0d got=%b exp=%b", k, rr_rvalid, exp_rv); end
         tick();
      end
      req = 3'b000; dev_gnt = 1'b0; dev_rvalid = 1'b1;
      #1;
      checks++; if (rr_rvalid !== 3'b100) begin errors++; $display("[TB] FAIL rr_drain_rvalid got=%b exp=100", rr_rvalid); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_stall();
      pulse_reset();
      req = 3'b010; dev_gnt = 1'b0;
      #1;
      checks++; if (fp_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_c0_req got=%b exp=1", fp_req); end
      checks++; if (fp_addr !== host_addr(1)) begin errors++; $display("[TB] FAIL stall_c0_addr got=%h exp=%h", fp_addr, host_addr(1)); end
      for (int c = 1; c < 3; c++) begin
         tick();
         req = 3'b011;
         #1;
         checks++; if (fp_addr !== host_addr(1)) begin errors++; $display("[TB] FAIL stall_c%0d_addr got=%h exp=%h", c, fp_addr, host_addr(1)); end
         checks++; if (fp_gnt !== 3'b000) begin errors++; $display("[TB] FAIL stall_c%0d_gnt got=%b exp=000", c, fp_gnt); end
      end
      tick();
      dev_gnt = 1'b1;
      #1;
      checks++; if (fp_gnt !== 3'b010) begin errors++; $display("[TB] FAIL stall_c3_gnt got=%b exp=010", fp_gnt); end
      tick();
      req = 3'b001;
      #1;
      checks++; if (fp_gnt !== 3'b001) begin errors++; $display("[TB] FAIL stall_c4_gnt got=%b exp=001", fp_gnt); end
      checks++; if (fp_addr !== host_addr(0)) begin errors++; $display("[TB] FAIL stall_c4_addr got=%h exp=%h", fp_addr, host_addr(0)); end
      tick();
      req = 3'b000; dev_gnt = 1'b0; dev_rvalid = 1'b1;
      #1;
      checks++; if (fp_rvalid !== 3'b010) begin errors++; $display("[TB] FAIL stall_resp1 got=%b exp=010", fp_rvalid); end
      tick();
      #1;
      checks++; if (fp_rvalid !== 3'b001) begin errors++; $display("[TB] FAIL stall_resp2 got=%b exp=001", fp_rvalid); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      req = 3'b001; dev_gnt = 1'b1;
      #1;
      checks++; if (fp_gnt !== 3'b001) begin errors++; $display("[TB] FAIL full_c0_gnt got=%b exp=001", fp_gnt); end
      tick();
      #1;
      checks++; if (fp_gnt !== 3'b001) begin errors++; $display("[TB] FAIL full_c1_gnt got=%b exp=001", fp_gnt); end
      tick();
      #1;
      checks++; if (fp_req !== 1'b0) begin errors++; $display("[TB] FAIL full_c2_req got=%b exp=0", fp_req); end
      dev_rvalid = 1'b1;
      #1;
      checks++; if (fp_req !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_req got=%b exp=0", fp_req); end
      checks++; if (fp_gnt !== 3'b000) begin errors++; $display("[TB] FAIL full_pop_gnt got=%b exp=000", fp_gnt); end
      checks++; if (fp_rvalid !== 3'b001) begin errors++; $display("[TB] FAIL full_pop_rvalid got=%b exp=001", fp_rvalid); end
      tick();
      dev_rvalid = 1'b0;
      #1;
      checks++; if (fp_req !== 1'b1) begin errors++; $display("[TB] FAIL full_c3_req got=%b exp=1", fp_req); end
      checks++; if (fp_gnt !== 3'b001) begin errors++; $display("[TB] FAIL full_c3_gnt got=%b exp=001", fp_gnt); end
      tick();
      req = 3'b000; dev_gnt = 1'b0; dev_rvalid = 1'b1;
      for (int c = 4; c < 6; c++) begin
         #1;
         checks++; if (fp_rvalid !== 3'b001) begin errors++; $display("[TB] FAIL full_drain_c%0d got=%b exp=001", c, fp_rvalid); end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_unexpected();
      pulse_reset();
      dev_rvalid = 1'b1; dev_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (fp_unexp !== 1'b1) begin errors++; $display("[TB] FAIL unexp_pulse got=%b exp=1", fp_unexp); end
      checks++; if (fp_rvalid !== 3'b000) begin errors++; $display("[TB] FAIL unexp_rvalid got=%b exp=000", fp_rvalid); end
      tick();
      dev_rvalid = 1'b0;
      #1;
      checks++; if (fp_unexp !== 1'b0) begin errors++; $display("[TB] FAIL unexp_clear got=%b exp=0", fp_unexp); end
      tick();
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      req = 3'b001; dev_gnt = 1'b1;
      tick();
      tick();
      rst = 1'b1; req = 3'b111; dev_rvalid = 1'b1;
      #1;
      checks++; if (fp_gnt !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_gnt got=%b exp=000", fp_gnt); end
      checks++; if (fp_rvalid !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_rvalid got=%b exp=000", fp_rvalid); end
      checks++; if (fp_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_dev_req got=%b exp=0", fp_req); end
      checks++; if (fp_unexp !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_unexp got=%b exp=0", fp_unexp); end
      tick();
      rst = 1'b0; req = 3'b000; dev_gnt = 1'b0;
      #1;
      checks++; if (fp_unexp !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_unexp got=%b exp=1", fp_unexp); end
      checks++; if (fp_rvalid !== 3'b000) begin errors++; $display("[TB] FAIL post_rst_rvalid got=%b exp=000", fp_rvalid); end
      tick();
      clear_inputs();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      we = 3'b010;
      be = {4'hC, 4'h3, 4'hF};
      for (int h = 0; h < N; h++) begin
         addr[h*AW +: AW]  = host_addr(h);
         wdata[h*DW +: DW] = 32'hA0 + 32'(h);
      end
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_stall();
      test_back_to_back();
      test_unexpected();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
